// File: rtl/bicolor_matrix_pkg.sv
// Shared constants, FSM state type and colour helpers
// for the bicolor matrix animator.
package bicolor_matrix_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [1:0] COL_OFF    = 2'b00;
    localparam logic [1:0] COL_RED    = 2'b01;
    localparam logic [1:0] COL_GREEN  = 2'b10;
    localparam logic [1:0] COL_YELLOW = 2'b11;

    typedef enum logic {
        IDLE,
        MOVE
    } state_t;

    function automatic logic has_red(input logic [1:0] c);
        return |(c & COL_RED);
    endfunction

    function automatic logic has_green(input logic [1:0] c);
        return |(c & COL_GREEN);
    endfunction

endpackage

// File: rtl/bicolor_matrix_animator_tick.sv
// Divider producing a one-cycle tick every DIV clocks;
// a synchronous clear restarts the count from zero.
module matrix_tick_gen #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(DIV - 1));
    assign tick = last && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bicolor_matrix_animator.sv
// Row-scan driver for a red/green dot matrix showing N_OBJ
// sprites that slide between a left and a right bank.
module bicolor_matrix_animator
    import bicolor_matrix_pkg::*;
#(
    parameter int                 ROWS      = 8,
    parameter int                 COLS      = 8,
    parameter int                 N_OBJ     = 3,
    parameter int                 OBJ_H     = 2,
    parameter int                 OBJ_W     = 2,
    parameter logic [2*N_OBJ-1:0] OBJ_COLOR = 6'b10_11_01,
    parameter int                 SCAN_DIV  = 1000,
    parameter int                 STEP_DIV  = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N_OBJ-1:0] cmd_mask,
    input  logic             cmd_dir,
    output logic             done,
    output logic             err,
    output logic [N_OBJ-1:0] bank,
    output logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  r,
    output logic [COLS-1:0]  g
);

    localparam int D    = COLS - OBJ_W;
    localparam int PW   = (D > 0) ? $clog2(D + 1) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BAND = OBJ_H + 1;
    localparam logic [COLS-1:0] BASE = COLS'((1 << OBJ_W) - 1);

    state_t state, state_nxt;

    logic [N_OBJ-1:0][PW-1:0] pos;
    logic [N_OBJ-1:0]         mask_q;
    logic                     dir_q;
    logic [PW-1:0]            step_cnt;
    logic [RW-1:0]            row_cnt;
    logic [ROWS-1:0]          row_nxt;
    logic [COLS-1:0]          r_nxt;
    logic [COLS-1:0]          g_nxt;

    logic scan_tick;
    logic step_tick;
    logic accept;
    logic legal;
    logic go;
    logic bad;
    logic last_step;

    matrix_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .tick (scan_tick)
    );

    matrix_tick_gen #(.DIV(STEP_DIV)) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .tick (step_tick)
    );

    // Objects rest only at a bank, so the bank bits fully
    // describe whether a group sits at the source side.
    always_comb begin
        accept = cmd_valid && (state == IDLE);
        if (cmd_dir == DIR_RIGHT) begin
            legal = |cmd_mask && ~|(cmd_mask & bank);
        end else begin
            legal = |cmd_mask && ~|(cmd_mask & ~bank);
        end
        go        = accept && legal;
        bad       = accept && !legal;
        last_step = (state == MOVE) && step_tick
                    && (step_cnt == PW'(D - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (go) begin
                    state_nxt = MOVE;
                end
            end
            MOVE: begin
                if (last_step) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q   <= '0;
            dir_q    <= DIR_LEFT;
            step_cnt <= '0;
            bank     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            pos      <= '0;
        end else begin
            done <= last_step;
            err  <= bad;
            if (go) begin
                mask_q   <= cmd_mask;
                dir_q    <= cmd_dir;
                step_cnt <= '0;
            end else if (state == MOVE && step_tick) begin
                step_cnt <= step_cnt + 1'b1;
                for (int i = 0; i < N_OBJ; i++) begin
                    if (mask_q[i]) begin
                        pos[i] <= dir_q ? pos[i] + 1'b1
                                        : pos[i] - 1'b1;
                    end
                end
                if (last_step) begin
                    bank <= dir_q ? (bank | mask_q)
                                  : (bank & ~mask_q);
                end
            end
        end
    end

    always_comb begin
        row_nxt          = '1;
        row_nxt[row_cnt] = 1'b0;
        r_nxt            = '0;
        g_nxt            = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (int'(row_cnt) >= i * BAND &&
                int'(row_cnt) <  i * BAND + OBJ_H) begin
                if (has_red(OBJ_COLOR[2*i +: 2])) begin
                    r_nxt = BASE << pos[i];
                end
                if (has_green(OBJ_COLOR[2*i +: 2])) begin
                    g_nxt = BASE << pos[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            row     <= '1;
            r       <= '0;
            g       <= '0;
        end else if (scan_tick) begin
            row     <= row_nxt;
            r       <= r_nxt;
            g       <= g_nxt;
            row_cnt <= (row_cnt == RW'(ROWS - 1)) ? '0
                                                  : row_cnt + 1'b1;
        end
    end

endmodule

// File: doc/bicolor_matrix_animator.md
Name: bicolor_matrix_animator

Overview:
Parametrised row-scan driver for a bicolor (red/green) dot-matrix that displays N_OBJ sprite objects, each a colour block on its own row band. Objects slide column-by-column between a left bank and a right bank on command. The block owns row scanning, per-object position state and move sequencing, and feeds the matrix pins directly. It generalises the fixed 8x8 three-animal display with a shift animation to arbitrary size, object count and group moves, and adds a valid/ready command handshake.

Parameters:
ROWS, 8, matrix rows
COLS, 8, matrix columns
N_OBJ, 3, number of objects; must satisfy N_OBJ*(OBJ_H+1)-1 <= ROWS
OBJ_H, 2, object height in rows
OBJ_W, 2, object width in columns; OBJ_W < COLS
OBJ_COLOR, 6'b10_11_01, 2 bits per object {g,r}; object i uses bits [2i+1:2i]
SCAN_DIV, 1000, clk cycles per row dwell (>=1)
STEP_DIV, 1000000, clk cycles per one-column animation step (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  move request
cmd_ready  out  1  block idle, request accepted this cycle when cmd_valid=1
cmd_mask  in  N_OBJ  objects to move together
cmd_dir  in  1  0 = toward left bank, 1 = toward right bank
done  out  1  one-cycle pulse, move completed
err  out  1  one-cycle pulse, command rejected
bank  out  N_OBJ  1 = object at right bank
row  out  ROWS  active-low one-hot row select
r  out  COLS  red column data, active-high
g  out  COLS  green column data, active-high

Behaviour:
- Reset (async): all pos=0 (left bank), bank=0, state IDLE, cmd_ready=1, done=err=0, row counter=0, row=all ones, r=g=0, both dividers cleared.
- Position: pos_i in 0..D, where D=COLS-OBJ_W. Column mask_i = ((1<<OBJ_W)-1) << pos_i; bit j drives column j. Left bank is pos 0, right bank is pos D.
- Scan: a row counter advances every SCAN_DIV cycles and wraps from ROWS-1 to 0. row, r and g are registered and update on the edge where the counter advances.
  - row[k]=0 only for the current row k.
  - If row k lies in band i (rows i*(OBJ_H+1) .. i*(OBJ_H+1)+OBJ_H-1): r = OBJ_COLOR[2i] ? mask_i : 0 and g = OBJ_COLOR[2i+1] ? mask_i : 0.
  - Rows outside every band output r=g=0.
  - The scan never stalls during moves.
- FSM IDLE:
  - cmd_ready=1. Accept on cmd_valid && cmd_ready at edge t.
  - Legal command: cmd_mask != 0 and every selected object sits at the source bank (pos 0 when dir=1, pos D when dir=0).
  - Legal command: latch mask and dir, clear the step counter, go to MOVE. cmd_ready is 0 from t+1.
  - Illegal command (mask=0, any selected object at the destination bank, or selected objects split across banks): err=1 for cycle t+1. Stay IDLE, cmd_ready stays 1, no state change.
- FSM MOVE:
  - On every STEP_DIV-th cycle after accept, each selected pos steps by +1 (dir=1) or -1 (dir=0).
  - The final step happens at edge t+D*STEP_DIV. Bank bits of the moved objects update on that edge, and done=1 with cmd_ready=1 in the following cycle; return to IDLE.
  - Unselected objects never move.
- cmd_valid while busy is ignored; the request must be held until cmd_ready. Changes to cmd_mask and cmd_dir mid-move have no effect.
- done and err are never asserted together. A new command may be accepted in the same cycle done is high.
- rst mid-move: immediate return to reset values; the interrupted move is lost and all objects jump to the left bank.
- Width rules: pos width is $clog2(D+1); the counters are sized $clog2(SCAN_DIV) and $clog2(STEP_DIV), minimum 1 bit.

Decomposition:
- Package bicolor_matrix_pkg:
  - direction constants DIR_LEFT=0 and DIR_RIGHT=1;
  - colour codes COL_OFF=2'b00, COL_RED=2'b01, COL_GREEN=2'b10, COL_YELLOW=2'b11;
  - FSM state enum {IDLE, MOVE}.
- Sub-module matrix_tick_gen #(DIV): counter with synchronous clear, one-cycle tick every DIV cycles, async rst. Instantiated twice: scan tick (free-running) and step tick (cleared on accept).

Test Plan:
- Reset, default parameters, SCAN_DIV=4 -> row sequences FE,FD,FB,...,7F with 4 cycles per row, wrapping.
  - Rows 0-1: r=03, g=00.
  - Rows 3-4: r=g=03.
  - Rows 6-7: g=03, r=00.
  - Rows 2 and 5: r=g=00.
- STEP_DIV=3, mask=001, dir=1 accepted at cycle t:
  - band 0 r column data steps 03,06,0C,18,30,60,C0 at t+3..t+18;
  - done=1 at t+19 only; bank=001; cmd_ready=0 for t+1..t+18.
- mask=110, dir=1 with both objects on the left -> both move in lockstep; done after 18 cycles; bank=111. Then mask=011, dir=0 -> both return; bank=100.
- Illegal commands:
  - mask=000 -> err pulse at t+1, no motion, cmd_ready stays 1.
  - With bank=001: mask=011, dir=1 (split banks) -> err.
  - With bank=001: mask=001, dir=1 (already at destination) -> err.
- cmd_valid held high with a new mask during a move -> not accepted until the cycle done=1. The new command is taken that cycle; the first command's motion is unaffected.
- rst asserted at t+7 of a move -> same cycle row=FF, r=g=00, all pos=0, cmd_ready=1; after release, scanning restarts from row 0.
